// File: rtl/audio_stream_transceiver.sv
// Purpose: SPI-fed audio frame receiver, frame FIFO and I2S/TDM serial transmitter.
// Latency: a frame pushed before b = F-1 is popped at b = F-1 and sent from the next b = 0.
// Backpressure: none; full-FIFO pushes are dropped (overflow), empty pops send zeros (underflow).

// Frame FIFO used between the SPI receiver and the serial transmitter.
// Latency: a pushed word is readable at pop_dat the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees a slot the same cycle.
module audio_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LEVEL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a full FIFO still takes a push when a pop frees a slot
    always_comb begin
        do_pop   = pop_vld && !empty;
        do_push  = push_vld && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

module audio_stream_transceiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MODE         = 0
) (
    input  logic                               serial_clk,
    input  logic                               reset,
    input  logic                               spi_chip_select,
    input  logic                               spi_mosi,
    input  logic                               mute,
    input  logic                               clear_flags,
    output logic                               i2s_ws,
    output logic                               i2s_sound_bit_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overflow,
    output logic                               underflow
);
    localparam int L   = CHANNELS * SAMPLE_WIDTH;
    localparam int RCW = $clog2(L);
    localparam int BW  = $clog2(SLOT_WIDTH);
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [RCW-1:0] RX_LAST   = RCW'(L - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(SLOT_WIDTH - 1);
    localparam logic [CW-1:0]  SLOT_LAST = CW'(CHANNELS - 1);

    // Receive side
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [L-2:0]   rx_sh_q, rx_sh_d;
    logic           push_vld;
    logic [L-1:0]   push_dat;

    // Transmit side: b is kept as (slot, bit) so no division is needed
    logic [BW-1:0]  bit_q, bit_d;
    logic [CW-1:0]  slot_q, slot_d;
    logic [CW-1:0]  next_slot;
    logic           tx_last;
    logic [L-1:0]   latch_q, latch_d;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic [SLOT_WIDTH-1:0]   slot_bits;
    logic           ws_q, ws_d;
    logic           sdo_q, sdo_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    // FIFO interface
    logic [L-1:0]   fifo_dat;
    logic [LW-1:0]  fifo_lvl;
    logic           fifo_full, fifo_empty;

    audio_stream_fifo #(
        .WIDTH (L),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (serial_clk),
        .rst      (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (tx_last),
        .pop_dat  (fifo_dat),
        .level    (fifo_lvl),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // SPI shift-in: push on the L-th bit, drop any partial frame when chip select rises
    always_comb begin
        push_dat = {rx_sh_q, spi_mosi};
        push_vld = 1'b0;
        rx_sh_d  = rx_sh_q;
        rx_cnt_d = '0;
        if (!spi_chip_select) begin
            rx_sh_d = push_dat[L-2:0];
            if (rx_cnt_q == RX_LAST) begin
                push_vld = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end
    end

    // Free-running frame counter, latch reload at b = F-1, and flag updates
    always_comb begin
        tx_last = (slot_q == SLOT_LAST) && (bit_q == BIT_LAST);
        bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        slot_d  = slot_q;
        if (bit_q == BIT_LAST) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        latch_d = latch_q;
        if (tx_last) begin
            latch_d = (fifo_empty || mute) ? '0 : fifo_dat;
        end
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // Full with a pop in the same cycle is not an overflow: the push is accepted
        if (push_vld && fifo_full && !tx_last) begin
            overflow_d = 1'b1;
        end
        if (tx_last && fifo_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Serial outputs for the coming counter value, so they can be registered
    always_comb begin
        sample = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (slot_d == CW'(c)) begin
                sample = latch_d[L-1-c*SAMPLE_WIDTH -: SAMPLE_WIDTH];
            end
        end
        // Bit k = 0 of a slot is the sample MSB; bits past the sample are padding zeros
        slot_bits = '0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            slot_bits[i] = sample[SAMPLE_WIDTH-1-i];
        end
        sdo_d = slot_bits[bit_d];
        next_slot = (slot_d == SLOT_LAST) ? '0 : slot_d + 1'b1;
        if (MODE == 0) begin
            // WS shows the channel of the following bit, leading the MSB by one
            ws_d = (bit_d == BIT_LAST) ? next_slot[0] : slot_d[0];
        end else begin
            ws_d = (slot_d == SLOT_LAST) && (bit_d == BIT_LAST);
        end
    end

    // State registers
    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) begin
            rx_cnt_q    <= '0;
            rx_sh_q     <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            latch_q     <= '0;
            ws_q        <= 1'b0;
            sdo_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rx_cnt_q    <= rx_cnt_d;
            rx_sh_q     <= rx_sh_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            latch_q     <= latch_d;
            ws_q        <= ws_d;
            sdo_q       <= sdo_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign i2s_ws            = ws_q;
    assign i2s_sound_bit_out = sdo_q;
    assign fifo_level        = fifo_lvl;
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;
endmodule
